// File: rtl/trace_capture_if.sv
//------------------------------------------------------------------------------
// Module  : trace_capture_if
// Purpose : Core trace bus and readout handshake channel for trace_capture.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface trace_capture_if #(
  parameter int XLEN = 32,
  parameter int TS_W = 16
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] aluResult;
  logic [XLEN-1:0] writeData;
  logic            memWrite;
  logic            branch;

  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_instr;
  logic [XLEN-1:0] rd_alu;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_memWrite;
  logic            rd_branch;
  logic [TS_W-1:0] rd_ts;

  modport master (
    output pc, instr, aluResult, writeData, memWrite, branch, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_alu, rd_wdata, rd_memWrite, rd_branch, rd_ts
  );

  modport slave (
    input  pc, instr, aluResult, writeData, memWrite, branch, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_alu, rd_wdata, rd_memWrite, rd_branch, rd_ts
  );
endinterface

`default_nettype wire

// File: rtl/trace_capture.sv
//------------------------------------------------------------------------------
// Module  : trace_capture
// Purpose : Qualified core-trace capture buffer (one-shot or ring) with
//           valid/ready readout of the oldest entry first.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_capture #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 16,
  parameter int CIRCULAR = 0
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  trace_capture_if.slave              bus,
  input  wire logic [1:0]             mode,
  input  wire logic                   arm,
  input  wire logic                   stop,
  output logic [1:0]                  state,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_EW   = 4*XLEN + 2 + TS_W;
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW:0]     r_count;
  logic [TS_W-1:0]   r_ts;
  logic              r_overflow;
  logic [c_EW-1:0]   r_mem [DEPTH];

  logic              w_qual;
  logic              w_full;
  logic              w_write;
  logic              w_xfer;
  logic              w_rd_valid;
  logic [c_AW-1:0]   w_rptr;
  logic [c_EW-1:0]   w_entry;
  logic [c_EW-1:0]   w_rd_entry;

  always_comb begin
    w_qual = 1'b1;
    case (mode)
      2'd0:    w_qual = 1'b1;
      2'd1:    w_qual = bus.memWrite;
      2'd2:    w_qual = bus.branch;
      default: w_qual = bus.memWrite | bus.branch;
    endcase
  end

  assign w_full     = (r_count == c_FULL);
  assign w_write    = (r_state == S_CAPTURE) && w_qual && ((CIRCULAR != 0) || !w_full);
  assign w_rd_valid = (r_state == S_READOUT);
  assign w_xfer     = w_rd_valid && bus.rd_ready;
  // Oldest entry sits count slots behind the write pointer; wraps for free.
  assign w_rptr     = r_wptr - r_count[c_AW-1:0];
  assign w_entry    = {bus.pc, bus.instr, bus.aluResult, bus.writeData,
                       bus.memWrite, bus.branch, r_ts};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (arm) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (stop || ((CIRCULAR == 0) && w_write && (r_count == c_FULL - 1'b1)))
          w_state_nxt = S_DONE;
      end
      S_DONE:    w_state_nxt = (r_count != '0) ? S_READOUT : S_IDLE;
      S_READOUT: begin
        if (stop || (w_xfer && (r_count == (c_AW+1)'(1))))
          w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_count    <= '0;
      r_ts       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_ts <= r_ts + 1'b1;
          if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
            // A full ring overwrites the oldest slot, so occupancy stays put.
            if (w_full) r_overflow <= 1'b1;
            else        r_count    <= r_count + 1'b1;
          end
        end
        S_READOUT: begin
          if (stop)        r_count <= '0;
          else if (w_xfer) r_count <= r_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wptr] <= w_entry;
  end

  assign w_rd_entry = w_rd_valid ? r_mem[w_rptr] : '0;

  assign {bus.rd_pc, bus.rd_instr, bus.rd_alu, bus.rd_wdata,
          bus.rd_memWrite, bus.rd_branch, bus.rd_ts} = w_rd_entry;
  assign bus.rd_valid = w_rd_valid;
  assign state        = r_state;
  assign count        = r_count;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture.sv
//------------------------------------------------------------------------------
// Module  : tb_trace_capture
// Purpose : Checks a one-shot and a ring trace_capture, driven in lockstep,
//           against a queue-style model, directed vectors and random traffic.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trace_capture;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TS_W  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic            arm, stop, rd_ready;
  logic [XLEN-1:0] pc, instr, alu, wdata;
  logic            mem_write, branch;

  logic [1:0]      state0, state1;
  logic [2:0]      count0, count1;
  logic            ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_capture_if #(.XLEN(XLEN), .TS_W(TS_W)) bus0 ();
  trace_capture_if #(.XLEN(XLEN), .TS_W(TS_W)) bus1 ();

  assign bus0.pc = pc;          assign bus1.pc = pc;
  assign bus0.instr = instr;    assign bus1.instr = instr;
  assign bus0.aluResult = alu;  assign bus1.aluResult = alu;
  assign bus0.writeData = wdata; assign bus1.writeData = wdata;
  assign bus0.memWrite = mem_write; assign bus1.memWrite = mem_write;
  assign bus0.branch = branch;  assign bus1.branch = branch;
  assign bus0.rd_ready = rd_ready; assign bus1.rd_ready = rd_ready;

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .CIRCULAR(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .mode(mode), .arm(arm), .stop(stop),
    .state(state0), .count(count0), .overflow(ovf0)
  );

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .CIRCULAR(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .mode(mode), .arm(arm), .stop(stop),
    .state(state1), .count(count1), .overflow(ovf1)
  );

  // Reference model: per instance a bounded FIFO (head + size) of entries.
  typedef struct {
    logic [XLEN-1:0] pc, instr, alu, wdata;
    logic            mw, br;
    int              ts;
  } entry_t;

  entry_t mbuf [2][DEPTH];
  int     mhead [2];
  int     msize [2];
  int     mst   [2];
  int     mts   [2];
  bit     movf  [2];

  function automatic bit qualifies();
    case (mode)
      2'd0:    return 1'b1;
      2'd1:    return mem_write;
      2'd2:    return branch;
      default: return mem_write | branch;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; msize[k] = 0; mst[k] = 0; mts[k] = 0; movf[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    entry_t e;
    for (int k = 0; k < 2; k++) begin
      case (mst[k])
        0: if (arm) begin
          mst[k] = 1; mhead[k] = 0; msize[k] = 0; mts[k] = 0; movf[k] = 1'b0;
        end
        1: begin
          if (qualifies()) begin
            e = '{pc, instr, alu, wdata, mem_write, branch, mts[k]};
            if (msize[k] == DEPTH) begin
              mbuf[k][mhead[k]] = e;
              mhead[k] = (mhead[k] + 1) % DEPTH;
              movf[k] = 1'b1;
            end else begin
              mbuf[k][(mhead[k] + msize[k]) % DEPTH] = e;
              msize[k]++;
            end
          end
          mts[k] = (mts[k] + 1) % (1 << TS_W);
          if (stop || (k == 0 && msize[k] == DEPTH)) mst[k] = 2;
        end
        2: mst[k] = (msize[k] != 0) ? 3 : 0;
        default: begin
          if (rd_ready) begin
            mhead[k] = (mhead[k] + 1) % DEPTH;
            msize[k]--;
          end
          if (stop) begin
            msize[k] = 0; mst[k] = 0;
          end else if (msize[k] == 0) begin
            mst[k] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic [1:0] st, input logic [2:0] cnt,
                           input logic ov, input logic rv,
                           input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] ri,
                           input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rw,
                           input logic rmw, input logic rbr, input logic [TS_W-1:0] rts);
    entry_t e;
    bit v;
    v = (mst[k] == 3);
    e = mbuf[k][mhead[k]];
    chk($sformatf("dut%0d.state", k),    st,  mst[k]);
    chk($sformatf("dut%0d.count", k),    cnt, msize[k]);
    chk($sformatf("dut%0d.overflow", k), ov,  movf[k]);
    chk($sformatf("dut%0d.rd_valid", k), rv,  v);
    chk($sformatf("dut%0d.rd_pc", k),    rpc, v ? e.pc    : '0);
    chk($sformatf("dut%0d.rd_instr", k), ri,  v ? e.instr : '0);
    chk($sformatf("dut%0d.rd_alu", k),   ra,  v ? e.alu   : '0);
    chk($sformatf("dut%0d.rd_wdata", k), rw,  v ? e.wdata : '0);
    chk($sformatf("dut%0d.rd_mw", k),    rmw, v ? e.mw    : 1'b0);
    chk($sformatf("dut%0d.rd_br", k),    rbr, v ? e.br    : 1'b0);
    chk($sformatf("dut%0d.rd_ts", k),    rts, v ? e.ts    : 0);
  endtask

  task automatic compare_all();
    check_dut(0, state0, count0, ovf0, bus0.rd_valid, bus0.rd_pc, bus0.rd_instr,
              bus0.rd_alu, bus0.rd_wdata, bus0.rd_memWrite, bus0.rd_branch, bus0.rd_ts);
    check_dut(1, state1, count1, ovf1, bus1.rd_valid, bus1.rd_pc, bus1.rd_instr,
              bus1.rd_alu, bus1.rd_wdata, bus1.rd_memWrite, bus1.rd_branch, bus1.rd_ts);
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_data(input logic [XLEN-1:0] p);
    pc = p; instr = p ^ 32'hA5A5_0000; alu = p + 32'd7; wdata = ~p;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, ".state0"}, state0, 2'd0);
    chk({tag, ".count0"}, count0, 3'd0);
    chk({tag, ".rv0"},    bus0.rd_valid, 1'b0);
    chk({tag, ".state1"}, state1, 2'd0);
    chk({tag, ".count1"}, count1, 3'd0);
    chk({tag, ".rv1"},    bus1.rd_valid, 1'b0);
    chk({tag, ".rdpc1"},  bus1.rd_pc, '0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic            arm;
    logic            rdy;
    logic [XLEN-1:0] pc;
    logic [1:0]      st;
    int              cnt;
    logic            rv;
    logic [XLEN-1:0] rpc;
    int              rts;
  } vec_t;

  vec_t tbl [10];

  initial begin
    reset = 1'b0; mode = 2'd0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    mem_write = 1'b0; branch = 1'b0;
    set_data('0);
    model_reset();
    #3;
    compare_all();
    @(posedge clk);
    #1 reset = 1'b1;

    // One-shot fill, DONE, in-order readout (expected values are for dut0 after each edge).
    tbl[0] = '{1'b1, 1'b0, 32'd0,  2'd1, 0, 1'b0, 32'd0,  0};
    tbl[1] = '{1'b0, 1'b0, 32'd0,  2'd1, 1, 1'b0, 32'd0,  0};
    tbl[2] = '{1'b0, 1'b0, 32'd4,  2'd1, 2, 1'b0, 32'd0,  0};
    tbl[3] = '{1'b0, 1'b0, 32'd8,  2'd1, 3, 1'b0, 32'd0,  0};
    tbl[4] = '{1'b0, 1'b0, 32'd12, 2'd2, 4, 1'b0, 32'd0,  0};
    tbl[5] = '{1'b0, 1'b1, 32'd16, 2'd3, 4, 1'b1, 32'd0,  0};
    tbl[6] = '{1'b0, 1'b1, 32'd20, 2'd3, 3, 1'b1, 32'd4,  1};
    tbl[7] = '{1'b0, 1'b1, 32'd24, 2'd3, 2, 1'b1, 32'd8,  2};
    tbl[8] = '{1'b0, 1'b1, 32'd28, 2'd3, 1, 1'b1, 32'd12, 3};
    tbl[9] = '{1'b0, 1'b1, 32'd32, 2'd0, 0, 1'b0, 32'd0,  0};
    for (int i = 0; i < 10; i++) begin
      arm = tbl[i].arm; rd_ready = tbl[i].rdy; set_data(tbl[i].pc);
      tick();
      chk($sformatf("vec%0d.state", i), state0, tbl[i].st);
      chk($sformatf("vec%0d.count", i), count0, tbl[i].cnt);
      chk($sformatf("vec%0d.rd_valid", i), bus0.rd_valid, tbl[i].rv);
      chk($sformatf("vec%0d.rd_pc", i), bus0.rd_pc, tbl[i].rpc);
      chk($sformatf("vec%0d.rd_ts", i), bus0.rd_ts, tbl[i].rts);
    end
    arm = 1'b0; rd_ready = 1'b0;
    async_reset("rst_after_vec");

    // memWrite-qualified capture, stop on capture cycle 7.
    mode = 2'd1; arm = 1'b1; tick(); arm = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_data(32'h100 + 32'(c));
      mem_write = (c == 2 || c == 5);
      stop = (c == 7);
      tick();
    end
    mem_write = 1'b0; stop = 1'b0;
    chk("mw.count0", count0, 3'd2);
    chk("mw.state0", state0, 2'd2);
    rd_ready = 1'b1;
    tick();
    chk("mw.ts_first", bus0.rd_ts, 4'd2);
    chk("mw.flag_first", bus0.rd_memWrite, 1'b1);
    tick();
    chk("mw.ts_second", bus0.rd_ts, 4'd5);
    chk("mw.flag_second", bus1.rd_memWrite, 1'b1);
    tick();
    chk("mw.idle", state0, 2'd0);
    rd_ready = 1'b0;

    // Ring overwrite, then stalled and resumed readout.
    mode = 2'd0; arm = 1'b1; tick(); arm = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_data(32'(4 * c));
      stop = (c == 5);
      tick();
    end
    stop = 1'b0;
    chk("ring.overflow", ovf1, 1'b1);
    chk("ring.count", count1, 3'd4);
    chk("ring.done", state1, 2'd2);
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d.rd_pc", s), bus1.rd_pc, 32'd8);
      chk($sformatf("stall%0d.rd_ts", s), bus1.rd_ts, 4'd2);
      chk($sformatf("stall%0d.count", s), count1, 3'd4);
      tick();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ring.rd_pc%0d", i), bus1.rd_pc, 32'(8 + 4 * i));
      tick();
    end
    chk("ring.idle", state1, 2'd0);
    chk("ring.rv_low", bus1.rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Asynchronous reset in the middle of a capture.
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    chk("midcap.count0", count0, 3'd2);
    async_reset("midcap");

    // Arm then stop with nothing qualifying.
    mode = 2'd2; branch = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("empty.capture", state0, 2'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("empty.done", state0, 2'd2);
    chk("empty.rv_done", bus0.rd_valid, 1'b0);
    tick();
    chk("empty.idle", state0, 2'd0);
    chk("empty.rv_idle", bus0.rd_valid, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      mode      = 2'($urandom_range(0, 3));
      arm       = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      rd_ready  = ($urandom_range(0, 1) == 1);
      mem_write = ($urandom_range(0, 2) == 0);
      branch    = ($urandom_range(0, 2) == 0);
      pc = $urandom; instr = $urandom; alu = $urandom; wdata = $urandom;
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
